// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory.
//
// Takes a byte stream over a valid/ready handshake and packs it into big-endian
// 32-bit words. The first byte of each word lands in [31:24]. The loader issues one
// write per word at consecutive word-aligned addresses starting at BASE_ADDR. It
// holds the CPU (cpu_hold) until the program image has been written.
//
// Optional feature (compile-time macro IMEM_LOADER_CHECKSUM_EN):
//   When the macro is defined, checksum is the modulo-2^32 sum of every word written
//   in the current load. When it is undefined, checksum is tied to zero and no
//   accumulator exists.
//
// Parameters:
//   DEPTH      number of instruction words the memory holds
//   BASE_ADDR  byte address of the first word written
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   start       one-cycle load request, honoured in IDLE or DONE only
//   word_count  number of words to load, latched with an accepted start
//   byte_in     stream data byte
//   byte_valid  byte_in valid this cycle
//   byte_ready  loader accepts a byte this cycle
//   we          memory write enable, one cycle per word
//   waddr       word-aligned byte address of the write
//   wdata       assembled instruction word
//   busy        load in progress (COLLECT or WRITE)
//   done        level, load finished (also set by a zero or rejected request)
//   err         level, last request rejected because word_count > DEPTH
//   cpu_hold    keeps the CPU in reset until the image is written
//   checksum    running sum of written words (zero unless the macro is defined)

module imem_loader #(
  parameter int unsigned DEPTH     = 4001,
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] word_count,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cpu_hold,
  output logic [31:0] checksum
);

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StWrite,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;   // words requested for this load
  logic [15:0] idx_q,   idx_d;     // index of the word being assembled/written
  logic [1:0]  bcnt_q,  bcnt_d;    // bytes of the current word received so far
  logic [31:0] shift_q, shift_d;   // big-endian assembly register
  logic        done_q,  done_d;
  logic        err_q,   err_d;

  logic        oversize;
  logic        start_take;         // start seen in a state that honours it

  assign oversize   = {16'd0, word_count} > DEPTH;
  assign start_take = start && ((state_q == StIdle) || (state_q == StDone));

  //--------------------------------------------------------------------------
  // Next-state logic and handshake outputs
  //--------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    idx_d      = idx_q;
    bcnt_d     = bcnt_q;
    shift_d    = shift_q;
    done_d     = done_q;
    err_d      = err_q;
    byte_ready = 1'b0;
    we         = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        // DONE honours start the same way as IDLE, so a finished loader can be
        // re-armed without passing through IDLE.
        if (start) begin
          count_d = word_count;
          idx_d   = '0;
          bcnt_d  = '0;
          shift_d = '0;
          err_d   = oversize;
          if ((word_count == 16'd0) || oversize) begin
            // Nothing to write: finish immediately without touching memory.
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StCollect;
            done_d  = 1'b0;
          end
        end
      end

      StCollect: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          shift_d = {shift_q[23:0], byte_in};
          bcnt_d  = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            state_d = StWrite;
          end
        end
      end

      StWrite: begin
        // Single write cycle. byte_ready stays low, so a byte offered now waits.
        we     = 1'b1;
        idx_d  = idx_q + 16'd1;
        bcnt_d = '0;
        if ((idx_q + 16'd1) == count_q) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          state_d = StCollect;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // State registers
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      count_q <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  //--------------------------------------------------------------------------
  // Memory-side and status outputs
  //--------------------------------------------------------------------------
  // The address is computed in 32 bits. idx_q never exceeds 16 bits, so the
  // address cannot wrap for any legal count.
  assign waddr    = BASE_ADDR + {14'd0, idx_q, 2'b00};
  assign wdata    = shift_q;
  assign busy     = (state_q == StCollect) || (state_q == StWrite);
  assign done     = done_q;
  assign err      = err_q;
  // An accepted load always clears done, so hold tracks done. Hold is high from
  // reset and re-asserts for every new load.
  assign cpu_hold = ~done_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (start_take) begin
      sum_d = '0;
    end else if (state_q == StWrite) begin
      sum_d = sum_q + shift_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader.
//
// Random byte streams are driven into the loader. The bench compares the writes it
// observes with a word list built directly from the byte stream: word i =
// {b[4i], b[4i+1], b[4i+2], b[4i+3]} at BASE + 4*i. The bench also checks status
// levels, latency, and boundary requests.
module tb_imem_loader;
  localparam int unsigned DEPTH = 4001;
  localparam logic [31:0] BASE  = 32'd0;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] word_count;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_hold;
  logic [31:0] checksum;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  imem_loader #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .word_count (word_count),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cpu_hold   (cpu_hold),
    .checksum   (checksum)
  );

  // Observed writes and sticky flags, sampled on the falling edge.
  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  bit          ready_seen;
  bit          ck_nonzero;

  always @(negedge clk) begin
    if (we === 1'b1) begin
      obs_addr.push_back(waddr);
      obs_data.push_back(wdata);
    end
    if (byte_ready === 1'b1) ready_seen = 1'b1;
    if (checksum !== 32'd0) ck_nonzero = 1'b1;
  end

  // Stimulus bytes and the reference word list derived from them.
  logic [7:0]  stim[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] exp_ck;

  task automatic build_model(input int count);
    logic [31:0] word;
    logic [31:0] sum;
    exp_addr.delete();
    exp_data.delete();
    sum = 32'd0;
    for (int i = 0; i < count; i++) begin
      word = {stim[4*i], stim[4*i+1], stim[4*i+2], stim[4*i+3]};
      exp_addr.push_back(BASE + 32'(4 * i));
      exp_data.push_back(word);
      sum = sum + word;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_ck = sum;
`else
    exp_ck = 32'd0;
`endif
  endtask

  task automatic random_stim(input int count);
    stim.delete();
    for (int i = 0; i < 4 * count; i++) stim.push_back(8'($urandom));
  endtask

  task automatic do_start(input logic [15:0] c);
    @(posedge clk); #1;
    start      = 1'b1;
    word_count = c;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  // Offer one byte and hold it until the loader takes it (bounded).
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    int n;
    byte_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
    end
    byte_in    = b;
    byte_valid = 1'b1;
    acc        = 1'b0;
    n          = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = (byte_ready === 1'b1);
      @(posedge clk); #1;
      n++;
    end
    byte_valid = 1'b0;
    if (!acc) begin
      tests_run++;
      tests_failed++;
      $display("FAIL byte_accept_timeout: byte %h not taken, byte_ready=%b expected 1", b, byte_ready);
    end
  endtask

  task automatic send_range(input int lo, input int hi, input int gap_max, input bit toggle);
    for (int i = lo; i < hi; i++) begin
      send_byte(stim[i], toggle ? 1 : int'($urandom_range(gap_max, 0)));
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (done === 1'b1) ok = 1'b1;
    end
  endtask

  //--------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({byte_ready, we, busy, done, err, cpu_hold} !== 6'b000001) begin
      tests_failed++;
      $display("FAIL reset_flags: {rdy,we,busy,done,err,hold}=%b expected 000001",
               {byte_ready, we, busy, done, err, cpu_hold});
    end
    tests_run++;
    if (waddr !== BASE || wdata !== 32'd0 || checksum !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_data: waddr=%h wdata=%h checksum=%h expected %h 0 0",
               waddr, wdata, checksum, BASE);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({byte_ready, we, busy, done, cpu_hold} !== 5'b00001) begin
      tests_failed++;
      $display("FAIL idle_after_reset: {rdy,we,busy,done,hold}=%b expected 00001",
               {byte_ready, we, busy, done, cpu_hold});
    end
  endtask

  task automatic test_single_word();
    stim.delete();
    stim.push_back(8'h81); stim.push_back(8'h41); stim.push_back(8'h00); stim.push_back(8'h04);
    obs_addr.delete(); obs_data.delete();
    do_start(16'd1);
    send_range(0, 4, 0, 1'b0);
    // 4th byte taken at the previous edge: the write must be in this cycle.
    @(negedge clk);
    tests_run++;
    if (we !== 1'b1 || waddr !== 32'h0 || wdata !== 32'h81410004) begin
      tests_failed++;
      $display("FAIL single_write: we=%b waddr=%h wdata=%h expected 1 00000000 81410004",
               we, waddr, wdata);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || we !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_done: done=%b cpu_hold=%b we=%b expected 1 0 0", done, cpu_hold, we);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (obs_addr.size() != 1) begin
      tests_failed++;
      $display("FAIL single_count: writes=%0d expected 1", obs_addr.size());
    end
  endtask

  task automatic test_toggle_valid();
    bit ok;
    int bad;
    random_stim(6);
    build_model(6);
    obs_addr.delete(); obs_data.delete();
    do_start(16'd6);
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL toggle_busy: busy=%b cpu_hold=%b done=%b expected 1 1 0", busy, cpu_hold, done);
    end
    send_range(0, 24, 0, 1'b1);
    wait_done(20, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL toggle_done_timeout: done=%b expected 1", done);
    end
    tests_run++;
    if (obs_addr.size() != 6) begin
      tests_failed++;
      $display("FAIL toggle_count: writes=%0d expected 6", obs_addr.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 6; i++) begin
        if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
          bad++;
          $display("FAIL toggle_write[%0d]: addr=%h data=%h expected %h %h",
                   i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
        end
      end
      if (bad != 0) tests_failed++;
    end
    tests_run++;
    if (checksum !== exp_ck) begin
      tests_failed++;
      $display("FAIL toggle_checksum: checksum=%h expected %h", checksum, exp_ck);
    end
  endtask

  task automatic test_oversize();
    obs_addr.delete(); obs_data.delete();
    ready_seen = 1'b0;
    do_start(16'd4002);
    @(negedge clk);
    tests_run++;
    if (err !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL oversize_flags: err=%b done=%b busy=%b expected 1 1 0", err, done, busy);
    end
    byte_in    = 8'hA5;
    byte_valid = 1'b1;
    repeat (6) @(negedge clk);
    byte_valid = 1'b0;
    tests_run++;
    if (obs_addr.size() != 0 || ready_seen) begin
      tests_failed++;
      $display("FAIL oversize_quiet: writes=%0d ready_seen=%b expected 0 0",
               obs_addr.size(), ready_seen);
    end
  endtask

  task automatic test_zero_count();
    obs_addr.delete(); obs_data.delete();
    do_start(16'd0);
    @(negedge clk);
    tests_run++;
    if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_flags: done=%b err=%b busy=%b expected 1 0 0", done, err, busy);
    end
    repeat (4) @(negedge clk);
    tests_run++;
    if (obs_addr.size() != 0) begin
      tests_failed++;
      $display("FAIL zero_writes: writes=%0d expected 0", obs_addr.size());
    end
  endtask

  task automatic test_busy_start();
    bit ok;
    int bad;
    random_stim(2);
    build_model(2);
    obs_addr.delete(); obs_data.delete();
    do_start(16'd2);
    send_range(0, 4, 1, 1'b0);
    // A zero-count request mid-load would finish the load early if it were honoured.
    start      = 1'b1;
    word_count = 16'd0;
    @(posedge clk); #1;
    start      = 1'b0;
    send_range(4, 8, 1, 1'b0);
    wait_done(20, ok);
    tests_run++;
    if (!ok || obs_addr.size() != 2) begin
      tests_failed++;
      $display("FAIL busy_start_count: done=%b writes=%0d expected 1 2", done, obs_addr.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 2; i++)
        if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) bad++;
      tests_run++;
      if (bad != 0) begin
        tests_failed++;
        $display("FAIL busy_start_data: w0=%h w1=%h expected %h %h",
                 obs_data[0], obs_data[1], exp_data[0], exp_data[1]);
      end
    end
  endtask

  task automatic test_reset_midload();
    bit ok;
    random_stim(5);
    obs_addr.delete(); obs_data.delete();
    do_start(16'd5);
    send_range(0, 10, 0, 1'b0);   // two words plus two bytes of the third
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if ({byte_ready, we, busy, done, cpu_hold} !== 5'b00001 || waddr !== BASE || wdata !== 32'd0) begin
      tests_failed++;
      $display("FAIL midload_reset: {rdy,we,busy,done,hold}=%b waddr=%h wdata=%h expected 00001 %h 0",
               {byte_ready, we, busy, done, cpu_hold}, waddr, wdata, BASE);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (obs_addr.size() != 2) begin
      tests_failed++;
      $display("FAIL midload_writes: writes=%0d expected 2", obs_addr.size());
    end
    stim.delete();
    stim.push_back(8'hDE); stim.push_back(8'hAD); stim.push_back(8'hBE); stim.push_back(8'hEF);
    obs_addr.delete(); obs_data.delete();
    do_start(16'd1);
    send_range(0, 4, 1, 1'b0);
    wait_done(10, ok);
    tests_run++;
    if (!ok || obs_addr.size() != 1) begin
      tests_failed++;
      $display("FAIL reload_count: done=%b writes=%0d expected 1 1", done, obs_addr.size());
    end else begin
      tests_run++;
      if (obs_addr[0] !== 32'h0 || obs_data[0] !== 32'hDEADBEEF) begin
        tests_failed++;
        $display("FAIL reload_write: addr=%h data=%h expected 00000000 deadbeef",
                 obs_addr[0], obs_data[0]);
      end
    end
  endtask

  task automatic test_checksum();
    bit ok;
    stim.delete();
    stim.push_back(8'h00); stim.push_back(8'h00); stim.push_back(8'h00); stim.push_back(8'h01);
    stim.push_back(8'hFF); stim.push_back(8'hFF); stim.push_back(8'hFF); stim.push_back(8'hFF);
    build_model(2);
    obs_addr.delete(); obs_data.delete();
    do_start(16'd2);
    send_range(0, 8, 0, 1'b0);
    wait_done(10, ok);
    tests_run++;
    if (!ok || checksum !== 32'h0 || obs_addr.size() != 2) begin
      tests_failed++;
      $display("FAIL checksum_wrap: done=%b checksum=%h writes=%0d expected 1 00000000 2",
               done, checksum, obs_addr.size());
    end
`ifndef IMEM_LOADER_CHECKSUM_EN
    tests_run++;
    if (ck_nonzero) begin
      tests_failed++;
      $display("FAIL checksum_idle: checksum seen nonzero=%b expected 0", ck_nonzero);
    end
`endif
  endtask

  task automatic test_random_loads();
    bit ok;
    int cnt;
    int bad;
    for (int r = 0; r < 5; r++) begin
      cnt = int'($urandom_range(8, 1));
      random_stim(cnt);
      build_model(cnt);
      obs_addr.delete(); obs_data.delete();
      do_start(16'(cnt));
      send_range(0, 4 * cnt, 2, 1'b0);
      wait_done(20, ok);
      bad = 0;
      if (obs_addr.size() != cnt) bad++;
      else
        for (int i = 0; i < cnt; i++)
          if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) bad++;
      tests_run++;
      if (!ok || bad != 0 || checksum !== exp_ck || cpu_hold !== 1'b0 || err !== 1'b0) begin
        tests_failed++;
        $display("FAIL random_load[%0d]: done=%b writes=%0d bad=%0d ck=%h hold=%b err=%b expected 1 %0d 0 %h 0 0",
                 r, done, obs_addr.size(), bad, checksum, cpu_hold, err, cnt, exp_ck);
      end
    end
  endtask

  task automatic test_max_depth();
    bit ok;
    int bad;
    random_stim(DEPTH);
    build_model(DEPTH);
    obs_addr.delete(); obs_data.delete();
    do_start(16'(DEPTH));
    send_range(0, 4 * DEPTH, 0, 1'b0);
    wait_done(20, ok);
    tests_run++;
    if (!ok || err !== 1'b0 || obs_addr.size() != DEPTH) begin
      tests_failed++;
      $display("FAIL depth_count: done=%b err=%b writes=%0d expected 1 0 %0d",
               done, err, obs_addr.size(), DEPTH);
    end else begin
      tests_run++;
      if (obs_addr[DEPTH-1] !== 32'h3E80) begin
        tests_failed++;
        $display("FAIL depth_last_addr: waddr=%h expected 00003e80", obs_addr[DEPTH-1]);
      end
      bad = 0;
      for (int i = 0; i < int'(DEPTH); i++)
        if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) bad++;
      tests_run++;
      if (bad != 0) begin
        tests_failed++;
        $display("FAIL depth_data: mismatching writes=%0d expected 0", bad);
      end
    end
  endtask

  initial begin
    start      = 1'b0;
    word_count = 16'd0;
    byte_in    = 8'd0;
    byte_valid = 1'b0;
    ready_seen = 1'b0;
    ck_nonzero = 1'b0;
    test_reset();
    test_single_word();
    test_toggle_valid();
    test_oversize();
    test_zero_count();
    test_busy_start();
    test_reset_midload();
    test_checksum();
    test_random_loads();
    test_max_depth();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
